// File: rtl/axis_uart_rx_if.sv
// AXI-Stream bundle between the UART receiver and the AXI-Lite UART master.
interface axis_if_uart #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport m_axis (output tdata, output tvalid, input tready);
  modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// UART receiver: deserializes parity-protected frames and packs DATA_BYTE
// bytes (MSB byte first) into one AXI-Stream word with a one-deep output
// register, error pulses and an inter-byte idle timeout.
module axis_uart_rx #(
  parameter int CLOCK               = 100_000_000,
  parameter int BAUD_RATE           = 115200,
  parameter int AXI_DATA_WIDTH_UART = 32,
  parameter int DATA_BITS           = 8,
  parameter int PARITY_BITS         = 1,
  parameter int STOP_BITS           = 1,
  parameter int TIMEOUT_BITS        = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        uart_rx,
  output logic        rx_done,
  output logic        parity_err,
  output logic        frame_err,
  output logic        rx_timeout,
  output logic        overrun,
  axis_if_uart.m_axis m_axis
);

  localparam int W           = AXI_DATA_WIDTH_UART;
  localparam int COUNT_SPEED = CLOCK / BAUD_RATE;
  localparam int DATA_BYTE   = W / DATA_BITS;
  localparam int CBAUD_W     = $clog2(COUNT_SPEED);
  localparam int CBIT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CBYTE_W     = (DATA_BYTE > 1) ? $clog2(DATA_BYTE) : 1;
  localparam int CIDLE_W     = $clog2(TIMEOUT_BITS + 1);
  localparam int IDX_W       = (W > 1) ? $clog2(W) : 1;

  localparam logic [CBAUD_W-1:0] BAUD_MID      = CBAUD_W'(COUNT_SPEED / 2 - 1);
  localparam logic [CBAUD_W-1:0] BAUD_LAST     = CBAUD_W'(COUNT_SPEED - 1);
  localparam logic [CBIT_W-1:0]  BIT_DATA_LAST = CBIT_W'(DATA_BITS - 1);
  localparam logic [CBIT_W-1:0]  BIT_STOP_LAST = CBIT_W'(STOP_BITS - 1);
  localparam logic [CBYTE_W-1:0] BYTE_LAST     = CBYTE_W'(DATA_BYTE - 1);
  localparam logic [CIDLE_W-1:0] IDLE_LAST     = CIDLE_W'(TIMEOUT_BITS - 1);
  localparam bit                 EVEN_PARITY   = (PARITY_BITS == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CBAUD_W-1:0]   count_baud_q, count_baud_d;
  logic [CBIT_W-1:0]    count_bit_q, count_bit_d;
  logic [CBYTE_W-1:0]   count_byte_q, count_byte_d;
  logic [CIDLE_W-1:0]   count_idle_q, count_idle_d;
  logic [W-1:0]         shreg_q, shreg_d;
  logic [W-1:0]         tdata_q, tdata_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 tvalid_q, tvalid_d;
  logic                 rx_done_q, rx_done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_timeout_q, rx_timeout_d;
  logic                 overrun_q, overrun_d;

  logic                 rx_s;
  logic                 baud_tick;
  logic                 mid_tick;
  logic                 last_stop;
  logic                 word_end;
  logic                 gap_tmo;
  logic                 ferr_word;
  logic                 par_expect;
  logic [IDX_W-1:0]     bit_idx;

  assign rx_s       = sync_q[1];
  assign baud_tick  = (count_baud_q == BAUD_LAST);
  assign mid_tick   = (count_baud_q == BAUD_MID);
  assign last_stop  = (state_q == S_STOP) && baud_tick && (count_bit_q == BIT_STOP_LAST);
  assign word_end   = last_stop && (count_byte_q == BYTE_LAST);
  assign gap_tmo    = (state_q == S_GAP) && rx_s && baud_tick && (count_idle_q == IDLE_LAST);
  // A low stop sample in this very cycle must count toward the word verdict.
  assign ferr_word  = ferr_q | ((state_q == S_STOP) & baud_tick & ~rx_s);
  assign par_expect = EVEN_PARITY ? par_q : ~par_q;
  // Byte k occupies slice [W-1-k*DATA_BITS -: DATA_BITS], filled LSB first.
  assign bit_idx    = IDX_W'((DATA_BYTE - 1 - int'(count_byte_q)) * DATA_BITS + int'(count_bit_q));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    // NOTE: a default on every path keeps combinational blocks from inferring latches.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_s) state_d = S_START;
      S_START:  if (mid_tick) begin
                  if (!rx_s)                   state_d = S_DATA;
                  else if (count_byte_q != '0) state_d = S_GAP;
                  else                         state_d = S_IDLE;
                end
      S_DATA:   if (baud_tick && count_bit_q == BIT_DATA_LAST) state_d = S_PARITY;
      S_PARITY: if (baud_tick) state_d = S_STOP;
      S_STOP:   if (last_stop) state_d = word_end ? S_IDLE : S_GAP;
      S_GAP:    if (!rx_s)        state_d = S_START;
                else if (gap_tmo) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, shift register, sticky flags, output register and pulses.
  always_comb begin
    sync_d       = {sync_q[0], uart_rx};
    count_baud_d = count_baud_q;
    count_bit_d  = count_bit_q;
    count_byte_d = count_byte_q;
    count_idle_d = count_idle_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    rx_done_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    rx_timeout_d = 1'b0;
    overrun_d    = 1'b0;

    if (tvalid_q && m_axis.tready) tvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        count_baud_d = '0;
        count_bit_d  = '0;
        count_idle_d = '0;
        par_d        = 1'b0;
      end
      S_START: begin
        count_baud_d = mid_tick ? '0 : count_baud_q + CBAUD_W'(1);
        count_bit_d  = '0;
        par_d        = 1'b0;
      end
      S_DATA: begin
        count_baud_d = baud_tick ? '0 : count_baud_q + CBAUD_W'(1);
        if (baud_tick) begin
          shreg_d[bit_idx] = rx_s;
          par_d            = par_q ^ rx_s;
          count_bit_d      = (count_bit_q == BIT_DATA_LAST) ? '0 : count_bit_q + CBIT_W'(1);
        end
      end
      S_PARITY: begin
        count_baud_d = baud_tick ? '0 : count_baud_q + CBAUD_W'(1);
        if (baud_tick && rx_s != par_expect) perr_d = 1'b1;
      end
      S_STOP: begin
        count_baud_d = baud_tick ? '0 : count_baud_q + CBAUD_W'(1);
        if (baud_tick) begin
          ferr_d      = ferr_word;
          count_bit_d = count_bit_q + CBIT_W'(1);
        end
        if (last_stop) begin
          count_bit_d = '0;
          if (!word_end) begin
            count_byte_d = count_byte_q + CBYTE_W'(1);
            count_idle_d = '0;
          end else begin
            count_byte_d = '0;
            perr_d       = 1'b0;
            ferr_d       = 1'b0;
            parity_err_d = perr_q;
            frame_err_d  = ferr_word;
            if (!perr_q && !ferr_word) begin
              // A word leaving in this same cycle frees the register for the new one.
              if (!tvalid_q || m_axis.tready) begin
                tdata_d   = shreg_q;
                tvalid_d  = 1'b1;
                rx_done_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end
        end
      end
      S_GAP: begin
        count_baud_d = baud_tick ? '0 : count_baud_q + CBAUD_W'(1);
        if (!rx_s) begin
          count_baud_d = '0;
        end else if (gap_tmo) begin
          rx_timeout_d = 1'b1;
          shreg_d      = '0;
          perr_d       = 1'b0;
          ferr_d       = 1'b0;
          count_byte_d = '0;
          count_idle_d = '0;
        end else if (baud_tick) begin
          count_idle_d = count_idle_q + CIDLE_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, the synchronizer idles high.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sync_q       <= 2'b11;
      count_baud_q <= '0;
      count_bit_q  <= '0;
      count_byte_q <= '0;
      count_idle_q <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_timeout_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      count_baud_q <= count_baud_d;
      count_bit_q  <= count_bit_d;
      count_byte_q <= count_byte_d;
      count_idle_q <= count_idle_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      rx_done_q    <= rx_done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_timeout_q <= rx_timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign rx_done       = rx_done_q;
  assign parity_err    = parity_err_q;
  assign frame_err     = frame_err_q;
  assign rx_timeout    = rx_timeout_q;
  assign overrun       = overrun_q;

endmodule
